berg_link_rx: RTL and testbench
===============================

# berg_link_rx

Receiving end of the 26-pin Berg ribbon link between EDiC boards: accepts bytes driven across the cable by the transmitting board using a 4-phase strobe/acknowledge handshake. Synchronizes the asynchronous strobe into the local clock domain and captures the byte. Buffers captured bytes in a small FIFO and presents them to local logic through a valid/ready interface. Applies backpressure to the remote transmitter by withholding acknowledge while the FIFO is full.

## Interface

Parameters:
- DEPTH, default 4: FIFO entries; power of two, 2..16.
- LVL_W, default $clog2(DEPTH)+1: width of fifo_level.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- nrst, input, 1: reset, asynchronous, active-low.
- cbl_data, input, 8: byte from cable; stable whenever cbl_stb is high.
- cbl_stb, input, 1: strobe from remote transmitter; asynchronous to clk.
- cbl_par, input, 1: even-parity bit over cbl_data; present only with BERG_LINK_PARITY_EN.
- cbl_ack, output, 1: acknowledge to remote transmitter; registered.
- out_data, output, 8: FIFO head byte; valid only while out_valid=1.
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts head when out_valid&out_ready at the clock edge.
- fifo_level, output, LVL_W: number of stored bytes, 0..DEPTH.
- par_err, output, 1: sticky parity error; present only with BERG_LINK_PARITY_EN.
- par_clr, input, 1: synchronous clear of par_err; present only with BERG_LINK_PARITY_EN.

## Operation

- cbl_stb passes through two flops (s1, s2); the FSM uses only s2 (stb_s). cbl_data is not synchronized; it is sampled only in the capture cycle, when the protocol guarantees it has been stable for at least two clocks.
- FSM states:
  - IDLE: cbl_ack=0. If stb_s=1 and fifo_level<DEPTH, write cbl_data into the FIFO, set cbl_ack=1, and go to WAIT_LOW. If stb_s=1 and the FIFO is full, stay in IDLE with ack low.
  - WAIT_LOW: cbl_ack=1. When stb_s=0, clear cbl_ack and go to IDLE. No capture occurs in this state.
- Exactly one FIFO write per strobe pulse. The strobe must return low before the next byte is accepted.
- FIFO: circular buffer with wrapping read/write pointers and a level counter.
  - out_data is the head entry (first-word fall-through).
  - A pop occurs when out_valid&out_ready.
  - A simultaneous push and pop leaves fifo_level unchanged.
- Full check in IDLE uses the level before the current edge: if the FIFO is full, a pop in the same cycle does not enable capture. Capture happens one cycle later.
- out_ready while empty has no effect.
- Reset, applied at any time including mid-handshake:
  - FSM goes to IDLE; cbl_ack=0.
  - s1=s2=0.
  - Pointers and level return to 0, so out_valid=0 and fifo_level=0.
  - par_err=0.
  - FIFO contents are discarded.
- Transmitter recovery after a reset: it sees ack stay low (or fall while stb is high) and must restart the byte. If stb is still high when reset releases, that byte is captured again. This is required behaviour.

## Timing

- cbl_stb rising before edge E0: s2 goes high at E1. The capture edge is E2, so cbl_ack and out_valid (if the FIFO was empty) are high after E2.
- Strobe-to-ack latency: 3 edges.
- cbl_stb falling before edge F0: cbl_ack goes low after F2.
- Minimum cable cycle: 6 clocks per byte.
- Pop at edge P: the next entry appears on out_data after P, or out_valid drops if the FIFO is now empty.
- Capture-to-consumer latency: 0 cycles, since out_valid follows the write edge.

## Configuration

- BERG_LINK_PARITY_EN defined:
  - cbl_par, par_err and par_clr exist.
  - At the capture edge, if ^{cbl_data,cbl_par} != 0, par_err is set.
  - The byte is still stored and acknowledged.
  - par_clr clears par_err; a set in the same cycle wins over the clear.
- BERG_LINK_PARITY_EN undefined: those ports and the parity logic are absent; all other behaviour is identical.

## Test plan

- Single byte: cbl_data=0xA5, stb raised → cbl_ack=1 and out_valid=1 with out_data=0xA5 exactly 3 edges later; stb dropped → ack=0 3 edges later; fifo_level=1.
- Backpressure: out_ready=0, send 5 bytes 0x01..0x05 with DEPTH=4 → bytes 1–4 acked, fifo_level=4, 5th strobe held with ack=0. Then one pop → 0x05 captured 1 cycle later; read order 0x01..0x05.
- Simultaneous push/pop at level 2 → level stays 2 and order is preserved. Pointer wrap: 10 bytes streamed through DEPTH=4 with out_ready=1 arrive in order.
- Long strobe: stb held high for 20 cycles → exactly one write and ack stays high; a second pulse writes a second byte.
- Reset mid-handshake: nrst low while in WAIT_LOW with level=3 → immediately ack=0, out_valid=0, fifo_level=0. Release with stb high → byte recaptured, level=1.
- Parity (macro on): byte 0x03 with par=1 → par_err=1 and byte still stored. par_clr pulse → par_err=0. Good byte 0x03 with par=0 → par_err stays 0.

Source files
------------

// File: rtl/berg_link_rx.sv
// Berg ribbon link receiver: strobe/ack capture into a FWFT FIFO with valid/ready output.
// Optional parity checking is enabled by defining BERG_LINK_PARITY_EN.
module berg_link_rx #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [7:0]       cbl_data,
    input  logic             cbl_stb,
`ifdef BERG_LINK_PARITY_EN
    input  logic             cbl_par,
    output logic             par_err,
    input  logic             par_clr,
`endif
    output logic             cbl_ack,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT_LOW} state_t;

    state_t           state_reg, state_next;
    logic             s1_reg, s2_reg;
    logic             stb_s;
    logic             full;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [7:0]       mem [DEPTH];

    // Two-flop synchronizer; cbl_data is deliberately left unsynchronized.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= cbl_stb;
            s2_reg <= s1_reg;
        end
    end

    assign stb_s = s2_reg;
    assign full  = (level_reg == LVL_W'(DEPTH));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (stb_s && !full) state_next = WAIT_LOW;
            WAIT_LOW: if (!stb_s)         state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Full check uses the pre-edge level, so a same-cycle pop cannot unblock capture.
    always_comb begin
        push = 1'b0;
        case (state_reg)
            IDLE:    push = stb_s && !full;
            default: push = 1'b0;
        endcase
    end

    assign cbl_ack = (state_reg == WAIT_LOW);

    assign out_valid  = (level_reg != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = mem[rd_ptr_reg];
    assign fifo_level = level_reg;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= cbl_data;
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

`ifdef BERG_LINK_PARITY_EN
    logic par_err_reg;

    // A parity error at capture takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                              par_err_reg <= 1'b0;
        else if (push && (^{cbl_data, cbl_par})) par_err_reg <= 1'b1;
        else if (par_clr)                       par_err_reg <= 1'b0;
    end

    assign par_err = par_err_reg;
`endif

endmodule

// File: tb/tb_berg_link_rx.sv
// Randomized self-checking bench for berg_link_rx against a queue-based behavioural model.
// Parity checks are included when BERG_LINK_PARITY_EN is defined.
module tb_berg_link_rx;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             nrst;
    logic [7:0]       cbl_data;
    logic             cbl_stb;
    logic             cbl_ack;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] fifo_level;
`ifdef BERG_LINK_PARITY_EN
    logic             cbl_par;
    logic             par_err;
    logic             par_clr;
    bit               rand_clr;
    bit               m_perr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: byte queue, two-clock strobe delay, ack-held flag.
    logic [7:0] q[$];
    bit         m_d1, m_d2, m_ack;
    bit         rand_rdy;
    int         rdy_pct;

    berg_link_rx #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cbl_data   (cbl_data),
        .cbl_stb    (cbl_stb),
`ifdef BERG_LINK_PARITY_EN
        .cbl_par    (cbl_par),
        .par_err    (par_err),
        .par_clr    (par_clr),
`endif
        .cbl_ack    (cbl_ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_d1  = 1'b0;
        m_d2  = 1'b0;
        m_ack = 1'b0;
`ifdef BERG_LINK_PARITY_EN
        m_perr = 1'b0;
`endif
    endtask

    task automatic model_edge();
        bit stb_s, full, cap, pp;
        if (nrst) begin
            stb_s = m_d2;
            full  = (q.size() == DEPTH);
            cap   = !m_ack && stb_s && !full;
            pp    = (q.size() != 0) && out_ready;
            if (pp)  void'(q.pop_front());
            if (cap) q.push_back(cbl_data);
            m_ack = m_ack ? stb_s : cap;
`ifdef BERG_LINK_PARITY_EN
            if (cap && (^{cbl_data, cbl_par})) m_perr = 1'b1;
            else if (par_clr)                  m_perr = 1'b0;
`endif
            m_d2 = m_d1;
            m_d1 = cbl_stb;
        end
    endtask

    task automatic compare_all();
        chk("ack", cbl_ack, m_ack);
        chk("valid", out_valid, (q.size() != 0));
        chk("level", fifo_level, q.size());
        if (q.size() != 0) chk("data", out_data, q[0]);
`ifdef BERG_LINK_PARITY_EN
        chk("par_err", par_err, m_perr);
`endif
    endtask

    // One clock: model update at the edge, new inputs just after, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 99) < rdy_pct);
`ifdef BERG_LINK_PARITY_EN
        if (rand_clr) par_clr = ($urandom_range(0, 19) == 0);
`endif
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ack_low();
        int n = 0;
        while (cbl_ack && n < 20) begin tick(); n++; end
        chk("ack_fall_bound", cbl_ack, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        cbl_data = b;
        cbl_stb  = 1'b1;
        while (!cbl_ack && n < 300) begin tick(); n++; end
        chk("ack_rise_bound", cbl_ack, 1'b1);
        cbl_stb = 1'b0;
        wait_ack_low();
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 40) begin tick(); n++; end
        out_ready = 1'b0;
        chk("drain_bound", out_valid, 1'b0);
    endtask

    initial begin
        nrst = 1'b0; cbl_data = 8'h00; cbl_stb = 1'b0; out_ready = 1'b0;
        rand_rdy = 1'b0; rdy_pct = 100;
`ifdef BERG_LINK_PARITY_EN
        cbl_par = 1'b0; par_clr = 1'b0; rand_clr = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        tick(); tick();
        chk("rst_ack", cbl_ack, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", fifo_level, 0);
        nrst = 1'b1;
        tick();

        // Single byte: ack and data appear on the third edge after stb rises.
        cbl_data = 8'hA5; cbl_stb = 1'b1;
        tick(); tick();
        chk("sb_ack_early", cbl_ack, 1'b0);
        tick();
        chk("sb_ack", cbl_ack, 1'b1);
        chk("sb_valid", out_valid, 1'b1);
        chk("sb_data", out_data, 8'hA5);
        cbl_stb = 1'b0;
        tick(); tick();
        chk("sb_ack_hold", cbl_ack, 1'b1);
        tick();
        chk("sb_ack_low", cbl_ack, 1'b0);
        chk("sb_level", fifo_level, 1);
        drain();

        // Backpressure: fifth byte waits until one entry is popped.
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("bp_level4", fifo_level, 4);
        cbl_data = 8'h05; cbl_stb = 1'b1;
        repeat (8) tick();
        chk("bp_held_ack", cbl_ack, 1'b0);
        chk("bp_held_level", fifo_level, 4);
        chk("bp_head", out_data, 8'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pop_ack", cbl_ack, 1'b0);
        chk("bp_pop_level", fifo_level, 3);
        tick();
        chk("bp_cap_ack", cbl_ack, 1'b1);
        chk("bp_cap_level", fifo_level, 4);
        cbl_stb = 1'b0;
        wait_ack_low();
        for (int v = 2; v <= 5; v++) begin
            chk("bp_order", out_data, 8'(v));
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        chk("bp_empty", out_valid, 1'b0);

        // Push and pop on the same edge at level 2.
        send(8'h11); send(8'h22);
        cbl_data = 8'h33; cbl_stb = 1'b1;
        tick(); tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pp_level", fifo_level, 2);
        chk("pp_head", out_data, 8'h22);
        chk("pp_ack", cbl_ack, 1'b1);
        cbl_stb = 1'b0;
        wait_ack_low();
        chk("pp_head2", out_data, 8'h22);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pp_tail", out_data, 8'h33);
        drain();

        // Pointer wrap with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(8'h40 + 8'(i));
        out_ready = 1'b0;
        drain();

        // Long strobe yields one write only.
        cbl_data = 8'h77; cbl_stb = 1'b1;
        repeat (20) tick();
        chk("ls_ack", cbl_ack, 1'b1);
        chk("ls_level", fifo_level, 1);
        cbl_stb = 1'b0;
        wait_ack_low();
        send(8'h88);
        chk("ls_level2", fifo_level, 2);
        chk("ls_head", out_data, 8'h77);
        drain();

        // Asynchronous reset while waiting for strobe low, then recapture.
        send(8'h01); send(8'h02);
        begin
            int n = 0;
            cbl_data = 8'h03; cbl_stb = 1'b1;
            while (!cbl_ack && n < 20) begin tick(); n++; end
        end
        chk("rm_level3", fifo_level, 3);
        chk("rm_wait_ack", cbl_ack, 1'b1);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("rm_ack", cbl_ack, 1'b0);
        chk("rm_valid", out_valid, 1'b0);
        chk("rm_level", fifo_level, 0);
        tick(); tick();
        nrst = 1'b1;
        tick(); tick(); tick();
        chk("rm_recap_level", fifo_level, 1);
        chk("rm_recap_data", out_data, 8'h03);
        cbl_stb = 1'b0;
        wait_ack_low();
        drain();

`ifdef BERG_LINK_PARITY_EN
        cbl_par = 1'b1;
        send(8'h03);
        chk("par_set", par_err, 1'b1);
        chk("par_stored", out_data, 8'h03);
        par_clr = 1'b1; tick(); par_clr = 1'b0;
        chk("par_clr", par_err, 1'b0);
        cbl_par = 1'b0;
        send(8'h03);
        chk("par_good", par_err, 1'b0);
        chk("par_level", fifo_level, 2);
        drain();
        rand_clr = 1'b1;
`endif

        // Randomized traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 160; i++) begin
            if (i % 20 == 0) begin
                case ($urandom_range(0, 3))
                    0:       rdy_pct = 20;
                    1:       rdy_pct = 50;
                    2:       rdy_pct = 90;
                    default: rdy_pct = 100;
                endcase
            end
`ifdef BERG_LINK_PARITY_EN
            cbl_par = (^cbl_data) ^ ($urandom_range(0, 7) == 0);
`endif
            repeat ($urandom_range(0, 3)) tick();
            send(8'($urandom));
        end
        rand_rdy = 1'b0;
`ifdef BERG_LINK_PARITY_EN
        rand_clr = 1'b0;
        par_clr  = 1'b0;
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
